// File: rtl/cnn_scan_ctrl_if.sv
// cnn_scan_ctrl_if: rd (req/addr/gnt/rvalid/rdata), pix (valid/data), res (valid/data/ready), wr (req/addr/data/gnt) channels; master=controller, slave=memory/datapath
interface cnn_scan_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic rd_gnt;
  logic rd_rvalid;
  logic [DATA_WIDTH-1:0] rd_rdata;
  logic pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic res_valid;
  logic [ACC_WIDTH-1:0] res_data;
  logic res_ready;
  logic wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ACC_WIDTH-1:0] wr_data;
  logic wr_gnt;
  modport master (
    output rd_req, rd_addr, pix_valid, pix_data, res_ready, wr_req, wr_addr, wr_data,
    input rd_gnt, rd_rvalid, rd_rdata, res_valid, res_data, wr_gnt
  );
  modport slave (
    input rd_req, rd_addr, pix_valid, pix_data, res_ready, wr_req, wr_addr, wr_data,
    output rd_gnt, rd_rvalid, rd_rdata, res_valid, res_data, wr_gnt
  );
endinterface

// File: rtl/cnn_scan_ctrl.sv
// cnn_scan_ctrl: raster-scan sequencer (clk_i, rst_i, start_i, input/output_base_i in; busy_o, done_o out; rd/pix/res/wr channels on bus master)
module cnn_scan_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic [ADDR_WIDTH-1:0] input_base_i,
  input  logic [ADDR_WIDTH-1:0] output_base_i,
  output logic busy_o,
  output logic done_o,
  cnn_scan_ctrl_if.master bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int OW = $clog2((IMG_W-2)*(IMG_H-2)+1);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_R, PUSH, WAIT_RES, WRITE, DONE} state_t;
  state_t state, state_d;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [OW-1:0] out_idx;
  logic [ADDR_WIDTH-1:0] in_base, out_base;
  logic [DATA_WIDTH-1:0] pix;
  logic [ACC_WIDTH-1:0] res;
  logic win, eol, last, adv;
  always_comb begin
    win = row >= RW'(2) && col >= CW'(2);
    eol = col == CW'(IMG_W-1);
    last = eol && row == RW'(IMG_H-1);
    adv = (state == PUSH && !win) || (state == WRITE && bus.wr_gnt);
    state_d = state;
    case (state)
      IDLE: state_d = start_i ? FETCH : IDLE;
      FETCH: state_d = bus.rd_gnt ? WAIT_R : FETCH;
      WAIT_R: state_d = bus.rd_rvalid ? PUSH : WAIT_R;
      PUSH: state_d = win ? WAIT_RES : last ? DONE : FETCH;
      WAIT_RES: state_d = bus.res_valid ? WRITE : WAIT_RES;
      WRITE: state_d = !bus.wr_gnt ? WRITE : last ? DONE : FETCH;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_o = state != IDLE;
    done_o = state == DONE;
    bus.rd_req = state == FETCH;
    bus.rd_addr = state == FETCH ? in_base + ADDR_WIDTH'(row) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(col) : '0;
    bus.pix_valid = state == PUSH;
    bus.pix_data = state == PUSH ? pix : '0;
    bus.res_ready = state == WAIT_RES;
    bus.wr_req = state == WRITE;
    bus.wr_addr = state == WRITE ? out_base + (ADDR_WIDTH'(out_idx) << 2) : '0;
    bus.wr_data = state == WRITE ? res : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      out_idx <= '0;
      in_base <= '0;
      out_base <= '0;
      pix <= '0;
      res <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && start_i) begin
        in_base <= input_base_i;
        out_base <= output_base_i;
        row <= '0;
        col <= '0;
        out_idx <= '0;
      end
      if (state == WAIT_R && bus.rd_rvalid) pix <= bus.rd_rdata;
      if (state == WAIT_RES && bus.res_valid) res <= bus.res_data;
      if (state == WRITE && bus.wr_gnt) out_idx <= out_idx + OW'(1);
      if (adv) begin
        col <= eol ? '0 : col + CW'(1);
        row <= last ? '0 : eol ? row + RW'(1) : row;
      end
    end
  end
endmodule

// File: tb/tb_cnn_scan_ctrl.sv
// tb_cnn_scan_ctrl: scoreboard bench for a 4x4 and a default 28x28 cnn_scan_ctrl
module tb_cnn_scan_ctrl;
  logic clk = 0;
  logic rst, start, start_b;
  logic [31:0] in_base, out_base, in_b, out_b;
  logic busy, done, busy_b, done_b;
  int errors = 0;
  int checks = 0;
  cnn_scan_ctrl_if #(.DATA_WIDTH(8), .ACC_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  cnn_scan_ctrl_if #(.DATA_WIDTH(8), .ACC_WIDTH(32), .ADDR_WIDTH(32)) bb ();
  cnn_scan_ctrl #(.IMG_W(4), .IMG_H(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .input_base_i(in_base), .output_base_i(out_base),
    .busy_o(busy), .done_o(done), .bus(bus)
  );
  cnn_scan_ctrl u_big (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .input_base_i(in_b), .output_base_i(out_b),
    .busy_o(busy_b), .done_o(done_b), .bus(bb)
  );
  always #5 clk = ~clk;
  logic [31:0] exp_rd[$];
  logic [7:0] exp_pix[$];
  logic [63:0] exp_wr[$];
  int rd_gnt_wait = 0;
  int wr_gnt_wait = 0;
  bit rv_same = 0;
  bit res_auto = 1;
  bit res_force = 0;
  int k = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  bit g, wg, rd_hold, wr_hold, rv_pend;
  logic [31:0] rd_held, ea;
  logic [63:0] wr_held, ew;
  logic [7:0] rv_data, ep;
  int nrd = 0;
  int nwr = 0;
  int bdone = 0;
  bit b_pend;
  logic [31:0] blast = 0;
  initial begin
    bus.rd_gnt = 0; bus.rd_rvalid = 0; bus.rd_rdata = 0;
    bus.res_valid = 0; bus.res_data = 0; bus.wr_gnt = 0;
    forever begin
      @(negedge clk);
      g = bus.rd_req && rd_cnt >= rd_gnt_wait;
      if (bus.rd_req && rd_hold) begin
        checks++;
        if (bus.rd_addr !== rd_held) begin errors++; $display("FAIL rd_addr_stable: got %h expected %h", bus.rd_addr, rd_held); end
      end
      if (g) begin
        checks++;
        if (exp_rd.size() == 0) begin errors++; $display("FAIL rd_order: read at %h expected none", bus.rd_addr); end
        else begin
          ea = exp_rd.pop_front();
          if (bus.rd_addr !== ea) begin errors++; $display("FAIL rd_addr: got %h expected %h", bus.rd_addr, ea); end
        end
      end
      rd_hold = bus.rd_req && !g;
      rd_held = bus.rd_addr;
      rd_cnt = rd_hold ? rd_cnt + 1 : 0;
      bus.rd_gnt = g;
      bus.rd_rvalid = rv_pend || (rv_same && g);
      bus.rd_rdata = rv_pend ? rv_data : 8'hEE;
      rv_pend = g;
      rv_data = bus.rd_addr[7:0];
      if (bus.pix_valid) begin
        checks++;
        if (exp_pix.size() == 0) begin errors++; $display("FAIL pix_order: pixel %h expected none", bus.pix_data); end
        else begin
          ep = exp_pix.pop_front();
          if (bus.pix_data !== ep) begin errors++; $display("FAIL pix_data: got %h expected %h", bus.pix_data, ep); end
        end
      end
      bus.res_valid = (res_auto && bus.res_ready) || res_force;
      bus.res_data = 32'hA0 + 32'(k);
      if (res_auto && bus.res_ready) k++;
      wg = bus.wr_req && wr_cnt >= wr_gnt_wait;
      if (bus.wr_req && wr_hold) begin
        checks++;
        if ({bus.wr_addr, bus.wr_data} !== wr_held) begin errors++; $display("FAIL wr_stable: got %h expected %h", {bus.wr_addr, bus.wr_data}, wr_held); end
      end
      if (wg) begin
        checks++;
        if (exp_wr.size() == 0) begin errors++; $display("FAIL wr_order: write %h expected none", {bus.wr_addr, bus.wr_data}); end
        else begin
          ew = exp_wr.pop_front();
          if ({bus.wr_addr, bus.wr_data} !== ew) begin errors++; $display("FAIL wr_addr_data: got %h expected %h", {bus.wr_addr, bus.wr_data}, ew); end
        end
      end
      wr_hold = bus.wr_req && !wg;
      wr_held = {bus.wr_addr, bus.wr_data};
      wr_cnt = wr_hold ? wr_cnt + 1 : 0;
      bus.wr_gnt = wg;
      if (done) begin
        done_cnt++;
        k = 0;
      end
    end
  end
  initial begin
    bb.rd_gnt = 0; bb.rd_rvalid = 0; bb.rd_rdata = 0;
    bb.res_valid = 0; bb.res_data = 0; bb.wr_gnt = 0;
    forever begin
      @(negedge clk);
      bb.rd_rvalid = b_pend;
      bb.rd_rdata = 8'(nrd);
      b_pend = bb.rd_req;
      bb.rd_gnt = bb.rd_req;
      if (bb.rd_req) begin
        checks++;
        if (bb.rd_addr !== in_b + 32'(nrd)) begin errors++; $display("FAIL big_rd_addr: got %h expected %h", bb.rd_addr, in_b + 32'(nrd)); end
        nrd++;
      end
      bb.res_valid = bb.res_ready;
      bb.res_data = 32'(nwr);
      bb.wr_gnt = bb.wr_req;
      if (bb.wr_req) begin
        checks++;
        if ({bb.wr_addr, bb.wr_data} !== {out_b + 32'(4*nwr), 32'(nwr)}) begin errors++; $display("FAIL big_wr: got %h expected %h", {bb.wr_addr, bb.wr_data}, {out_b + 32'(4*nwr), 32'(nwr)}); end
        blast = bb.wr_addr;
        nwr++;
      end
      if (done_b) bdone++;
    end
  end
  task automatic expect_image(input logic [31:0] ib, input logic [31:0] ob);
    logic [31:0] a;
    for (int p = 0; p < 16; p++) begin
      a = ib + 32'(p);
      exp_rd.push_back(a);
      exp_pix.push_back(a[7:0]);
    end
    for (int j = 0; j < 4; j++) exp_wr.push_back({ob + 32'(4*j), 32'hA0 + 32'(j)});
  endtask
  task automatic start_img(input logic [31:0] ib, input logic [31:0] ob);
    @(negedge clk);
    in_base = ib;
    out_base = ob;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input int target, input int limit, input string nm);
    for (int i = 0; i < limit && done_cnt < target; i++) @(posedge clk);
    checks++;
    if (done_cnt < target) begin errors++; $display("FAIL %s_timeout: done count %0d expected %0d", nm, done_cnt, target); end
    repeat (3) @(negedge clk);
  endtask
  task automatic check_end(input string nm, input int target);
    checks++;
    if (exp_rd.size() != 0 || exp_pix.size() != 0 || exp_wr.size() != 0) begin
      errors++; $display("FAIL %s_drain: left rd=%0d pix=%0d wr=%0d expected 0", nm, exp_rd.size(), exp_pix.size(), exp_wr.size());
    end
    checks++;
    if (done_cnt != target) begin errors++; $display("FAIL %s_done_count: got %0d expected %0d", nm, done_cnt, target); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: busy %b expected 0", nm, busy); end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bus.rd_req, bus.rd_addr, bus.pix_valid, bus.pix_data, bus.res_ready, bus.wr_req, bus.wr_addr, bus.wr_data} !== '0) begin
      errors++; $display("FAIL reset_outputs: busy=%b done=%b rd_req=%b wr_req=%b expected all 0", busy, done, bus.rd_req, bus.wr_req);
    end
    checks++;
    if ({busy_b, done_b, bb.rd_req, bb.wr_req, bb.res_ready, bb.pix_valid} !== '0) begin errors++; $display("FAIL reset_big: busy=%b expected 0", busy_b); end
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_stay_idle: busy %b expected 0", busy); end
  endtask
  task automatic test_basic();
    int t;
    t = done_cnt + 1;
    expect_image(32'h100, 32'h200);
    start_img(32'h100, 32'h200);
    wait_done(t, 1000, "basic");
    check_end("basic", t);
  endtask
  task automatic test_backpressure();
    int t;
    rd_gnt_wait = 3;
    wr_gnt_wait = 5;
    t = done_cnt + 1;
    expect_image(32'h100, 32'h200);
    start_img(32'h100, 32'h200);
    wait_done(t, 2000, "backpressure");
    check_end("backpressure", t);
    rd_gnt_wait = 0;
    wr_gnt_wait = 0;
  endtask
  task automatic test_start_busy();
    int t, i;
    t = done_cnt + 2;
    expect_image(32'h100, 32'h200);
    expect_image(32'h500, 32'h600);
    start_img(32'h100, 32'h200);
    repeat (3) begin
      repeat (7) @(negedge clk);
      in_base = 32'h900;
      out_base = 32'hA00;
      start = 1;
      @(negedge clk);
      start = 0;
    end
    i = 0;
    while (!done && i < 1000) begin @(negedge clk); i++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL start_busy_first_done: done %b expected 1", done); end
    in_base = 32'h700;
    out_base = 32'h800;
    start = 1;
    @(negedge clk);
    in_base = 32'h500;
    out_base = 32'h600;
    @(negedge clk);
    start = 0;
    wait_done(t, 1000, "start_busy");
    check_end("start_busy", t);
  endtask
  task automatic test_reset_mid();
    int t;
    res_auto = 0;
    expect_image(32'h100, 32'h200);
    start_img(32'h100, 32'h200);
    for (int i = 0; i < 300 && !bus.res_ready; i++) @(negedge clk);
    checks++;
    if (bus.res_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_reach: res_ready %b expected 1", bus.res_ready); end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({busy, done, bus.rd_req, bus.rd_addr, bus.pix_valid, bus.pix_data, bus.res_ready, bus.wr_req, bus.wr_addr, bus.wr_data} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: busy=%b res_ready=%b wr_req=%b expected all 0", busy, bus.res_ready, bus.wr_req);
    end
    rst = 0;
    res_force = 1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.res_ready, busy, bus.wr_req} !== 3'b000) begin errors++; $display("FAIL reset_mid_late_res: res_ready/busy/wr_req %b expected 000", {bus.res_ready, busy, bus.wr_req}); end
    end
    res_force = 0;
    res_auto = 1;
    exp_rd.delete();
    exp_pix.delete();
    exp_wr.delete();
    t = done_cnt + 1;
    expect_image(32'h340, 32'h480);
    start_img(32'h340, 32'h480);
    wait_done(t, 1000, "reset_mid");
    check_end("reset_mid", t);
  endtask
  task automatic test_rvalid_in_gnt();
    int t;
    rv_same = 1;
    t = done_cnt + 1;
    expect_image(32'h100, 32'h200);
    start_img(32'h100, 32'h200);
    wait_done(t, 1000, "rvalid_in_gnt");
    check_end("rvalid_in_gnt", t);
    rv_same = 0;
  endtask
  task automatic test_big();
    @(negedge clk);
    in_b = 32'h1000;
    out_b = 32'h8000;
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    for (int i = 0; i < 20000 && bdone == 0; i++) @(posedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (bdone != 1) begin errors++; $display("FAIL big_done: got %0d expected 1", bdone); end
    checks++;
    if (nrd != 784) begin errors++; $display("FAIL big_reads: got %0d expected 784", nrd); end
    checks++;
    if (nwr != 676) begin errors++; $display("FAIL big_writes: got %0d expected 676", nwr); end
    checks++;
    if (blast !== 32'h8A8C) begin errors++; $display("FAIL big_last_addr: got %h expected 00008a8c", blast); end
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL big_idle: busy %b expected 0", busy_b); end
  endtask
  initial begin
    rst = 1;
    start = 0;
    start_b = 0;
    in_base = 0;
    out_base = 0;
    in_b = 0;
    out_b = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_rvalid_in_gnt();
    test_big();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
